// File: rtl/alu_console_pkg.sv
// ============================================================================
// alu_console_pkg : shared op encodings, flag indices and 7-seg glyph table
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_console_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    localparam int FLAG_ZF = 3;
    localparam int FLAG_SF = 2;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 0;

    // Returns {g,f,e,d,c,b,a} active-low.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_console_key.sv
// ============================================================================
// key_debounce : 2-FF synchroniser, level debounce and rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_state;
    logic          r_state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_state   <= 1'b0;
            r_state_q <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], btn};
            r_state_q <= r_state;
            if (r_sync[1] == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_state <= ~r_state;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign pulse = r_state & ~r_state_q;

endmodule

`default_nettype wire

// File: rtl/alu_console.sv
// ============================================================================
// alu_console : button-loaded A/B/OP registers, registered ALU, hex scanner
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_console
    import alu_console_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEBOUNCE = 20000,
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = WIDTH / 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  data,
    input  logic              btn_a,
    input  logic              btn_b,
    input  logic              btn_op,
    input  logic [1:0]        view,
    output logic [WIDTH-1:0]  result,
    output logic [3:0]        flags,
    output logic              valid,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg
);

    localparam int SHW = $clog2(WIDTH);
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] C_SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] C_DIGIT_LAST = DW'(DIGITS - 1);

    logic [2:0] w_btn;
    logic [2:0] w_pulse;
    logic       w_any_ld;

    assign w_btn    = {btn_op, btn_b, btn_a};
    assign w_any_ld = |w_pulse;

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (w_btn[gi]),
            .pulse (w_pulse[gi])
        );
    end

    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [3:0]       r_op, r_flags;
    logic             r_valid, r_pending;

    logic [WIDTH:0]   w_sum, w_diff;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_cf, w_of;
    logic [3:0]       w_flags;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    assign w_sh   = r_b[SHW-1:0];

    always_comb begin
        w_res = '0;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        case (r_op)
            ALU_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cf  = w_sum[WIDTH];
                w_of  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_cf  = w_diff[WIDTH];
                w_of  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            ALU_AND:   w_res = r_a & r_b;
            ALU_OR:    w_res = r_a | r_b;
            ALU_XOR:   w_res = r_a ^ r_b;
            ALU_SLL:   w_res = r_a << w_sh;
            ALU_SRL:   w_res = r_a >> w_sh;
            ALU_SRA:   w_res = $signed(r_a) >>> w_sh;
            ALU_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            ALU_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            ALU_PASSB: w_res = r_b;
            default:   w_res = '0;
        endcase
    end

    // Undefined opcodes must report all-zero flags, including ZF.
    always_comb begin
        w_flags = '0;
        if (r_op <= ALU_PASSB) begin
            w_flags[FLAG_ZF] = (w_res == '0);
            w_flags[FLAG_SF] = w_res[WIDTH-1];
            w_flags[FLAG_CF] = w_cf;
            w_flags[FLAG_OF] = w_of;
        end
    end

    // A load always wins over a pending execute, so valid waits for a clean cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_valid   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (w_pulse[0]) r_a  <= data;
            if (w_pulse[1]) r_b  <= data;
            if (w_pulse[2]) r_op <= data[WIDTH-1 -: 4];
            if (w_any_ld) begin
                r_valid   <= 1'b0;
                r_pending <= 1'b1;
            end else if (r_pending) begin
                r_result  <= w_res;
                r_flags   <= w_flags;
                r_valid   <= 1'b1;
                r_pending <= 1'b0;
            end
        end
    end

    logic [SW-1:0]     r_scan;
    logic [DW-1:0]     r_digit;
    logic [DIGITS-1:0] r_sel;
    logic [7:0]        r_seg;
    logic [WIDTH-1:0]  w_src;
    logic [3:0]        w_nib;
    logic              w_dp_n;

    always_comb begin
        case (view)
            2'd0:    w_src = r_result;
            2'd1:    w_src = r_a;
            2'd2:    w_src = r_b;
            default: w_src = {{(WIDTH-8){1'b0}}, r_flags, r_op};
        endcase
    end

    assign w_nib  = w_src[{r_digit, 2'b00} +: 4];
    assign w_dp_n = ~((r_digit == '0) && !r_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_digit <= '0;
            r_sel   <= ~DIGITS'(1);
            r_seg   <= 8'hFF;
        end else begin
            if (r_scan == C_SCAN_LAST) begin
                r_scan  <= '0;
                r_digit <= (r_digit == C_DIGIT_LAST) ? '0 : r_digit + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
            r_sel <= ~(DIGITS'(1) << r_digit);
            r_seg <= {w_dp_n, hex_glyph(w_nib)};
        end
    end

    assign result = r_result;
    assign flags  = r_flags;
    assign valid  = r_valid;
    assign sel    = r_sel;
    assign seg    = r_seg;

endmodule

`default_nettype wire

// File: tb/tb_alu_console.sv
// ============================================================================
// tb_alu_console : directed self-checking bench for alu_console
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data = '0;
    logic        btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0;
    logic [1:0]  view = 2'd0;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        valid;
    logic [7:0]  sel, seg;

    int n_cmp = 0;
    int n_err = 0;

    // Active-low {g..a} glyphs for hex 0-F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [3:0]  ops [11] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd1, 4'd0};
    logic [31:0] ers [11] = '{32'h0, 32'h80000021, 32'h80000021, 32'h0, 32'h40000000,
                              32'hC0000000, 32'h1, 32'h0, 32'h21, 32'h7FFFFFDF, 32'h80000021};
    logic [3:0]  efl [11] = '{4'h8, 4'h4, 4'h4, 4'h8, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h4};

    always #5 clk = ~clk;

    alu_console #(.WIDTH(32), .DEBOUNCE(4), .SCAN_DIV(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (data),
        .btn_a  (btn_a),
        .btn_b  (btn_b),
        .btn_op (btn_op),
        .view   (view),
        .result (result),
        .flags  (flags),
        .valid  (valid),
        .sel    (sel),
        .seg    (seg)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press, hold until accepted (edge 6), loaded (7) and executed (8), then release.
    task automatic press(input logic [2:0] which, input logic [31:0] d);
        data = d;
        {btn_op, btn_b, btn_a} = which;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (k == 7) begin
                n_cmp++;
                if (valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL press_load_clears_valid: got %b expected 0", valid);
                end
            end
        end
        n_cmp++;
        if (valid !== 1'b1) begin
            n_err++;
            $display("FAIL press_latency_valid: got %b expected 1", valid);
        end
        {btn_op, btn_b, btn_a} = 3'b000;
        tick(10);
    endtask

    task automatic test_reset;
        logic [7:0] prev_sel;
        logic [7:0] one;
        logic [7:0] exp_seg;
        int         exp_d;
        int         changes;
        rst_n = 1'b0;
        tick(2);
        n_cmp++;
        if (result !== 32'h0 || flags !== 4'h0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: got res=%h fl=%h v=%b expected 0/0/0", result, flags, valid);
        end
        n_cmp++;
        if (seg !== 8'hFF || sel !== 8'hFE) begin
            n_err++;
            $display("FAIL reset_display: got seg=%h sel=%h expected FF/FE", seg, sel);
        end
        rst_n    = 1'b1;
        one      = 8'h01;
        prev_sel = sel;
        exp_d    = 0;
        changes  = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            n_cmp++;
            if (valid !== 1'b0 || result !== 32'h0) begin
                n_err++;
                $display("FAIL idle_state: got v=%b res=%h expected 0/0", valid, result);
            end
            if (sel !== prev_sel) begin
                exp_d = (exp_d + 1) % 8;
                n_cmp++;
                if (sel !== ~(one << exp_d)) begin
                    n_err++;
                    $display("FAIL sel_sequence: got %h expected %h", sel, ~(one << exp_d));
                end
                changes++;
                prev_sel = sel;
            end
            exp_seg = (sel == 8'hFE) ? 8'h40 : 8'hC0;
            n_cmp++;
            if (seg !== exp_seg) begin
                n_err++;
                $display("FAIL idle_seg: got %h expected %h (sel=%h)", seg, exp_seg, sel);
            end
        end
        n_cmp++;
        if (changes < 8) begin
            n_err++;
            $display("FAIL sel_scan_rate: got %0d changes expected >= 8", changes);
        end
    endtask

    task automatic test_add_basic;
        press(3'b001, 32'd7);
        press(3'b010, 32'd5);
        press(3'b100, 32'h0);
        n_cmp++;
        if (result !== 32'd12 || flags !== 4'h0) begin
            n_err++;
            $display("FAIL add_basic: got res=%h fl=%h expected 0000000c/0", result, flags);
        end
    endtask

    task automatic test_add_overflow;
        press(3'b001, 32'h7FFFFFFF);
        press(3'b010, 32'h1);
        press(3'b100, 32'h0);
        n_cmp++;
        if (result !== 32'h80000000 || flags !== 4'h5) begin
            n_err++;
            $display("FAIL add_overflow: got res=%h fl=%h expected 80000000/5", result, flags);
        end
    endtask

    task automatic test_sub_sltu;
        press(3'b001, 32'h0);
        press(3'b010, 32'h1);
        press(3'b100, {4'd1, 28'h0});
        n_cmp++;
        if (result !== 32'hFFFFFFFF || flags !== 4'h6) begin
            n_err++;
            $display("FAIL sub_borrow: got res=%h fl=%h expected ffffffff/6", result, flags);
        end
        press(3'b100, {4'd9, 28'h0});
        n_cmp++;
        if (result !== 32'h1 || flags !== 4'h0) begin
            n_err++;
            $display("FAIL sltu: got res=%h fl=%h expected 00000001/0", result, flags);
        end
    endtask

    task automatic test_ops;
        press(3'b001, 32'h80000000);
        press(3'b010, 32'h21);
        for (int i = 0; i < 11; i++) begin
            press(3'b100, {ops[i], 28'h0});
            n_cmp++;
            if (result !== ers[i] || flags !== efl[i]) begin
                n_err++;
                $display("FAIL op_%0d: got res=%h fl=%h expected %h/%h",
                         ops[i], result, flags, ers[i], efl[i]);
            end
        end
    endtask

    task automatic test_bounce;
        int   falls;
        logic pv;
        falls = 0;
        pv    = valid;
        data  = 32'h100;
        for (int k = 0; k < 42; k++) begin
            if (k < 20)      btn_a = ((k / 2) % 2 == 0);
            else if (k < 32) btn_a = 1'b1;
            else             btn_a = 1'b0;
            tick(1);
            if (pv && !valid) falls++;
            pv = valid;
        end
        n_cmp++;
        if (falls != 1) begin
            n_err++;
            $display("FAIL bounce_loads: got %0d expected 1", falls);
        end
        n_cmp++;
        if (result !== 32'h121 || valid !== 1'b1) begin
            n_err++;
            $display("FAIL bounce_result: got res=%h v=%b expected 00000121/1", result, valid);
        end
    endtask

    task automatic test_simultaneous;
        int   rises;
        logic pv;
        rises = 0;
        pv    = valid;
        data  = 32'h3;
        {btn_b, btn_a} = 2'b11;
        for (int k = 0; k < 30; k++) begin
            if (k == 12) {btn_b, btn_a} = 2'b00;
            tick(1);
            if (!pv && valid) rises++;
            pv = valid;
        end
        n_cmp++;
        if (rises != 1) begin
            n_err++;
            $display("FAIL simul_execs: got %0d expected 1", rises);
        end
        n_cmp++;
        if (result !== 32'h6) begin
            n_err++;
            $display("FAIL simul_a_plus_b: got %h expected 00000006", result);
        end
        press(3'b100, {4'd12, 28'h0});
        n_cmp++;
        if (result !== 32'h0 || flags !== 4'h0) begin
            n_err++;
            $display("FAIL undefined_op: got res=%h fl=%h expected 0/0", result, flags);
        end
    endtask

    task automatic test_display;
        logic [31:0] src;
        logic [7:0]  one;
        logic [7:0]  exp_seg;
        int          d;
        one  = 8'h01;
        view = 2'd1;
        press(3'b001, 32'h12345678);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                view = 2'd3;
                tick(2);
            end
            src = (pass == 0) ? 32'h12345678 : 32'h0000000C;
            for (int k = 0; k < 16; k++) begin
                tick(1);
                d = -1;
                for (int j = 0; j < 8; j++) if (sel === ~(one << j)) d = j;
                n_cmp++;
                if (d < 0) begin
                    n_err++;
                    $display("FAIL disp_sel_onehot: got %h expected one-hot-low", sel);
                end else begin
                    exp_seg = {1'b1, glyph[src[d*4 +: 4]]};
                    if (seg !== exp_seg) begin
                        n_err++;
                        $display("FAIL disp_view%0d_digit%0d: got %h expected %h",
                                 view, d, seg, exp_seg);
                    end
                end
            end
        end
        view = 2'd0;
    endtask

    task automatic test_reset_mid;
        data  = 32'h55;
        btn_a = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (result !== 32'h0 || valid !== 1'b0 || sel !== 8'hFE || seg !== 8'hFF) begin
            n_err++;
            $display("FAIL async_reset: got res=%h v=%b sel=%h seg=%h expected 0/0/fe/ff",
                     result, valid, sel, seg);
        end
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            n_cmp++;
            if (valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_early_load: cycle %0d got v=%b expected 0", k, valid);
            end
        end
        tick(1);
        n_cmp++;
        if (valid !== 1'b1 || result !== 32'h55) begin
            n_err++;
            $display("FAIL reset_mid_load: got v=%b res=%h expected 1/00000055", valid, result);
        end
        btn_a = 1'b0;
        tick(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_basic();
        test_add_overflow();
        test_sub_sltu();
        test_ops();
        test_bounce();
        test_simultaneous();
        test_display();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
